// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// master: the controller (takes opcode/mem_ready, drives enables, selects, debug state).
// slave:  the datapath side (drives opcode/mem_ready, consumes the controls).
interface mips_multicycle_control_if;
  logic [5:0] opcode;        // IR[31:26]
  logic       mem_ready;     // memory finished the current access this cycle
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;     // 00 B, 01 const 4, 10 imm, 11 imm<<2
  logic [1:0] alu_op;        // 00 add, 01 sub, 10 funct
  logic [1:0] pc_source;     // 00 ALU, 01 ALUOut, 10 jump target
  logic       illegal_op;    // pulse in DECODE on an unsupported opcode
  logic [3:0] state;         // debug view of the FSM state

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: fetch/decode/execute/memory/write-back
// sequencing with Moore outputs; FETCH, MEMRD and MEMWR stall until mem_ready.
// Ports: clk, reset (async, active-high), bus (mips_multicycle_control_if.master).
// Optional build macro MIPS_CTRL_ADDI_EN adds addi support (states ADDIEX/ADDIWB);
// without it opcode 001000 is reported as illegal.
module mips_multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  mips_multicycle_control_if.master   bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
`ifdef MIPS_CTRL_ADDI_EN
    ,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
`endif
  } state_t;

  state_t state_q, state_d;

  logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       mem_to_reg_c, ir_write_c, reg_write_c, reg_dst_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;
  logic       illegal_op_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    mem_to_reg_c    = 1'b0;
    ir_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    reg_dst_c       = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 2'b00;
    pc_source_c     = 2'b00;
    illegal_op_c    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
        state_d     = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target PC + (imm<<2) is precomputed here into ALUOut.
        alu_src_b_c = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default: begin
            state_d      = FETCH;
            illegal_op_c = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        // IR is held, so the opcode is still valid here.
        if (bus.opcode == OP_LW)      state_d = MEMRD;
        else if (bus.opcode == OP_SW) state_d = MEMWR;
        else                          state_d = FETCH;
      end
      MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        state_d    = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        state_d     = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = RWB;
      end
      RWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
        state_d         = FETCH;
      end
      JUMP: begin
        pc_write_c  = 1'b1;
        pc_source_c = 2'b10;
        state_d     = FETCH;
      end
`ifdef MIPS_CTRL_ADDI_EN
      ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = FETCH;
      end
`endif
      default: state_d = FETCH;  // unused codes recover with all outputs low
    endcase
  end

  // Reset pulls state to FETCH asynchronously; the strobes are also masked by
  // reset directly so FETCH's mem_ready-gated writes cannot fire while held.
  assign bus.pc_write      = pc_write_c      & ~reset;
  assign bus.pc_write_cond = pc_write_cond_c & ~reset;
  assign bus.ir_write      = ir_write_c      & ~reset;
  assign bus.reg_write     = reg_write_c     & ~reset;
  assign bus.mem_write     = mem_write_c     & ~reset;
  assign bus.i_or_d        = i_or_d_c;
  assign bus.mem_read      = mem_read_c;
  assign bus.mem_to_reg    = mem_to_reg_c;
  assign bus.reg_dst       = reg_dst_c;
  assign bus.alu_src_a     = alu_src_a_c;
  assign bus.alu_src_b     = alu_src_b_c;
  assign bus.alu_op        = alu_op_c;
  assign bus.pc_source     = pc_source_c;
  assign bus.illegal_op    = illegal_op_c;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: stimulus pushes the expected state and
// control word for every cycle it drives; a monitor pops and compares at each falling
// edge, or immediately when an asynchronous-reset sample is requested.
module tb_mips_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk;
  logic reset;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] outs;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;
  event chk_ev;

  // Word layout: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
  // ir_write, reg_write, reg_dst, alu_src_a, alu_src_b[1:0], alu_op[1:0],
  // pc_source[1:0], illegal_op.
  function automatic logic [16:0] pack(input logic pw, pwc, iod, mr, mw, m2r, irw, rw,
                                       rd, asa, input logic [1:0] asb, aop, psrc,
                                       input logic ill);
    return {pw, pwc, iod, mr, mw, m2r, irw, rw, rd, asa, asb, aop, psrc, ill};
  endfunction

  // Expected control word for a state, written out from the controller's output table.
  function automatic logic [16:0] exp_out(input logic [3:0] st, input logic rdy,
                                          input logic rst, input logic ill);
    logic g;
    g = rdy & ~rst;
    case (st)
      4'd0:  return pack(g, 0, 0, 1, 0, 0, g, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      4'd1:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, ill);
      4'd2:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      4'd3:  return pack(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      4'd4:  return pack(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      4'd5:  return pack(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      4'd6:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
      4'd7:  return pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      4'd8:  return pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
      4'd9:  return pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
      4'd10: return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      4'd11: return pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      default: return '0;
    endcase
  endfunction

  function automatic logic [16:0] act_out();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.mem_to_reg, bus.ir_write, bus.reg_write, bus.reg_dst, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic rst,
                      input logic ill);
    exp_t e;
    e.st   = st;
    e.outs = exp_out(st, rdy, rst, ill);
    e.id   = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive inputs just after the edge, record what this cycle must show.
  task automatic step(input logic [5:0] opc, input logic rdy, input logic rst,
                      input logic [3:0] st, input logic ill);
    bus.opcode    = opc;
    bus.mem_ready = rdy;
    reset         = rst;
    push(st, rdy, rst, ill);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.state !== e.st) begin
          errors++;
          $display("FAIL state_v%0d: got %0d expected %0d", e.id, bus.state, e.st);
        end
        checks++;
        if (act_out() !== e.outs) begin
          errors++;
          $display("FAIL ctrl_v%0d (state %0d): got %b expected %b", e.id, e.st,
                   act_out(), e.outs);
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.opcode    = OP_R;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Held in reset: FETCH with writes masked even though mem_ready is high.
    step(OP_LW, 1, 1, 0, 0);
    step(OP_LW, 1, 1, 0, 0);

    // lw: 0,1,2,3,4
    step(OP_LW, 1, 0, 0, 0);
    step(OP_LW, 1, 0, 1, 0);
    step(OP_LW, 1, 0, 2, 0);
    step(OP_LW, 1, 0, 3, 0);
    step(OP_LW, 1, 0, 4, 0);

    // R-type with a 2-cycle fetch stall: 0,0,0,1,6,7
    step(OP_R, 0, 0, 0, 0);
    step(OP_R, 0, 0, 0, 0);
    step(OP_R, 1, 0, 0, 0);
    step(OP_R, 1, 0, 1, 0);
    step(OP_R, 1, 0, 6, 0);
    step(OP_R, 1, 0, 7, 0);

    // beq: 0,1,8
    step(OP_BEQ, 1, 0, 0, 0);
    step(OP_BEQ, 1, 0, 1, 0);
    step(OP_BEQ, 1, 0, 8, 0);

    // j: 0,1,9
    step(OP_J, 1, 0, 0, 0);
    step(OP_J, 1, 0, 1, 0);
    step(OP_J, 1, 0, 9, 0);

    // illegal opcode: 0,1(illegal_op) then straight back to FETCH
    step(OP_BAD, 1, 0, 0, 0);
    step(OP_BAD, 1, 0, 1, 1);

    // addi
    step(OP_ADDI, 1, 0, 0, 0);
`ifdef MIPS_CTRL_ADDI_EN
    step(OP_ADDI, 1, 0, 1, 0);
    step(OP_ADDI, 1, 0, 10, 0);
    step(OP_ADDI, 1, 0, 11, 0);
`else
    step(OP_ADDI, 1, 0, 1, 1);
`endif

    // lw with one stall cycle in MEMRD: 0,1,2,3,3,4
    step(OP_LW, 1, 0, 0, 0);
    step(OP_LW, 1, 0, 1, 0);
    step(OP_LW, 1, 0, 2, 0);
    step(OP_LW, 0, 0, 3, 0);
    step(OP_LW, 1, 0, 3, 0);
    step(OP_LW, 1, 0, 4, 0);

    // sw stalled in MEMWR, then reset asserted mid-cycle.
    step(OP_SW, 1, 0, 0, 0);
    step(OP_SW, 1, 0, 1, 0);
    step(OP_SW, 1, 0, 2, 0);
    step(OP_SW, 0, 0, 5, 0);
    bus.mem_ready = 1'b0;
    push(4'd5, 0, 0, 0);
    #6;                       // past the falling edge, well before the next rise
    reset = 1'b1;
    #1;
    push(4'd0, 0, 1, 0);      // async: FETCH, mem_write gone, no clock edge yet
    -> chk_ev;
    @(posedge clk);
    #1;
    step(OP_SW, 1, 1, 0, 0);

    // Release: first FETCH completes, then sw runs with no stall: 0,1,2,5
    step(OP_SW, 1, 0, 0, 0);
    step(OP_SW, 1, 0, 1, 0);
    step(OP_SW, 1, 0, 2, 0);
    step(OP_SW, 1, 0, 5, 0);
    step(OP_R, 1, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
